// File: rtl/ifetch_blkbuf.sv
// Instruction fetch block buffer: requests 128-bit blocks from the I-cache and
// hands out 32-bit instructions with their PC, one per decode handshake.
package tcore_param;
  localparam int XLEN     = 32;
  localparam int BLK_SIZE = 128;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] addr;
    logic            uncached;
    logic            ready;
  } icache_req_t;

  typedef struct packed {
    logic                valid;
    logic [BLK_SIZE-1:0] blk;
    logic                ready;
  } icache_res_t;
endpackage

module ifetch_blkbuf
  import tcore_param::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            uncached_i,
  output icache_req_t     icache_req_o,
  input  icache_res_t     icache_res_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  input  logic            inst_ready_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SERVE
  } state_t;

  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

  state_t                r_state;
  logic [XLEN-1:0]       r_pc;
  logic [BLK_SIZE-1:0]   r_blk;
  logic                  r_discard;

  logic [XLEN-1:0]       w_redirPc;
  logic [XLEN-1:0]       w_pcInc;
  logic                  w_lastWord;
  logic [6:0]            w_wordIdx;
  logic                  w_unused;

  assign w_redirPc  = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign w_pcInc    = r_pc + 32'd4;
  assign w_lastWord = (r_pc[3:2] == 2'b11);
  assign w_wordIdx  = {r_pc[3:2], 5'b00000};
  assign w_unused   = ^redirect_pc_i[1:0];

  // A redirect while a request is in flight sets r_discard so the stale block is dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC_ALIGNED;
      r_blk     <= '0;
      r_discard <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (redirect_valid_i) r_pc <= w_redirPc;
          r_state <= S_REQ;
        end
        S_REQ: begin
          if (redirect_valid_i) r_pc <= w_redirPc;
          if (icache_res_i.ready) begin
            r_state   <= S_WAIT;
            r_discard <= redirect_valid_i;
          end
        end
        S_WAIT: begin
          if (icache_res_i.valid) begin
            r_discard <= 1'b0;
            if (redirect_valid_i) begin
              r_pc    <= w_redirPc;
              r_state <= S_REQ;
            end else if (r_discard) begin
              r_state <= S_REQ;
            end else begin
              r_blk   <= icache_res_i.blk;
              r_state <= S_SERVE;
            end
          end else if (redirect_valid_i) begin
            r_pc      <= w_redirPc;
            r_discard <= 1'b1;
          end
        end
        S_SERVE: begin
          if (redirect_valid_i) begin
            r_pc    <= w_redirPc;
            r_state <= S_REQ;
          end else if (inst_ready_i) begin
            r_pc <= w_pcInc;
            if (w_lastWord) r_state <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    icache_req_o = '0;
    inst_valid_o = 1'b0;
    inst_o       = '0;
    inst_pc_o    = '0;
    case (r_state)
      S_REQ: begin
        icache_req_o.valid    = 1'b1;
        icache_req_o.addr     = {r_pc[XLEN-1:4], 4'b0000};
        icache_req_o.uncached = uncached_i;
      end
      S_WAIT: icache_req_o.ready = 1'b1;
      S_SERVE: begin
        inst_valid_o = 1'b1;
        inst_pc_o    = r_pc;
        inst_o       = r_blk[w_wordIdx +: XLEN];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ifetch_blkbuf.sv
// Scoreboard bench for ifetch_blkbuf: directed redirects against a small
// I-cache responder; monitors check every request address and served instruction.
module tb_ifetch_blkbuf;
  import tcore_param::*;

  localparam int W_REQ_VALID  = 0;
  localparam int W_RESP_READY = 1;
  localparam int W_INST_VALID = 2;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } instExp_t;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          redirectValid;
  logic [31:0]   redirectPc;
  logic          uncachedDrive;
  icache_req_t   icacheReq;
  icache_res_t   icacheRes;
  logic          resValid;
  logic [127:0]  resBlk;
  logic          resReady;
  logic          instValid;
  logic [31:0]   instWord;
  logic [31:0]   instPc;
  logic          instReady;

  int            errors = 0;
  int            checks = 0;
  int            respLatency = 1;
  int            respLat;
  int            respWait;
  logic [31:0]   respBase;
  instExp_t      instQ[$];
  logic [31:0]   addrQ[$];
  instExp_t      monEntry;

  assign icacheRes = {resValid, resBlk, resReady};

  always #5 clk_i = ~clk_i;

  ifetch_blkbuf #(.RESET_PC(32'h8000_0000)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .redirect_valid_i (redirectValid),
    .redirect_pc_i    (redirectPc),
    .uncached_i       (uncachedDrive),
    .icache_req_o     (icacheReq),
    .icache_res_i     (icacheRes),
    .inst_valid_o     (instValid),
    .inst_o           (instWord),
    .inst_pc_o        (instPc),
    .inst_ready_i     (instReady)
  );

  function automatic logic [31:0] wordAt(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [127:0] blkFor(input logic [31:0] base);
    logic [127:0] b;
    if (base == 32'h8000_0000) begin
      b = 128'h33333333_22222222_11111111_00000000;
    end else begin
      for (int i = 0; i < 4; i++) b[i*32 +: 32] = wordAt(base + 32'(i * 4));
    end
    return b;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic redir, input logic [31:0] pc);
    redirectValid = redir;
    redirectPc    = pc;
  endtask

  task automatic pushInst(input logic [31:0] pc, input logic [31:0] inst);
    instExp_t e;
    e.inst = inst;
    e.pc   = pc;
    instQ.push_back(e);
  endtask

  task automatic pushRange(input logic [31:0] firstPc, input int count);
    for (int i = 0; i < count; i++) pushInst(firstPc + 32'(i * 4), wordAt(firstPc + 32'(i * 4)));
  endtask

  task automatic waitHandshakes(input int n, input string tag);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < 300) begin
      @(negedge clk_i);
      cyc++;
      if (instValid && instReady) seen++;
    end
    if (seen < n) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: timeout, handshakes=%0d required=%0d", tag, seen, n);
    end
  endtask

  task automatic waitOn(input int which, input string tag);
    int cyc = 0;
    logic hit = 1'b0;
    while (!hit && cyc < 300) begin
      @(negedge clk_i);
      cyc++;
      case (which)
        W_REQ_VALID:  hit = icacheReq.valid;
        W_RESP_READY: hit = icacheReq.ready;
        default:      hit = instValid;
      endcase
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: timeout waiting, seen=0 required=1", tag);
    end
  endtask

  // Scoreboard monitors: request addresses and served instructions, popped on handshake.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (icacheReq.valid && resReady) begin
        if (addrQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL reqAddr: unexpected request actual=%h required=none", icacheReq.addr);
        end else begin
          checkOutput("reqAddr", icacheReq.addr, addrQ.pop_front());
        end
      end
      if (instValid && instReady) begin
        if (instQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL inst: unexpected instruction actual=%h pc=%h required=none", instWord, instPc);
        end else begin
          monEntry = instQ.pop_front();
          checkOutput("instWord", instWord, monEntry.inst);
          checkOutput("instPc", instPc, monEntry.pc);
        end
      end
    end
  end

  // I-cache responder: returns the block for each accepted address after respLatency cycles.
  initial begin
    resValid = 1'b0;
    resBlk   = '0;
    forever begin
      @(negedge clk_i);
      if (rst_ni && icacheReq.valid && resReady) begin
        respBase = icacheReq.addr;
        respLat  = respLatency;
        @(posedge clk_i); #1;
        repeat (respLat - 1) begin
          @(posedge clk_i); #1;
        end
        resValid = 1'b1;
        resBlk   = blkFor(respBase);
        respWait = 0;
        while (respWait < 50) begin
          @(negedge clk_i);
          if (icacheReq.ready) break;
          respWait++;
        end
        @(posedge clk_i); #1;
        resValid = 1'b0;
        resBlk   = '0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_ni        = 1'b0;
    uncachedDrive = 1'b0;
    instReady     = 1'b1;
    resReady      = 1'b1;
    applyStimulus(1'b0, 32'h0);

    addrQ.push_back(32'h8000_0000);
    addrQ.push_back(32'h8000_0010);
    pushInst(32'h8000_0000, 32'h0000_0000);
    pushInst(32'h8000_0004, 32'h1111_1111);
    pushInst(32'h8000_0008, 32'h2222_2222);
    pushInst(32'h8000_000C, 32'h3333_3333);

    repeat (2) @(posedge clk_i);
    #3;
    checkOutput("resetReqValid", icacheReq.valid, 1'b0);
    checkOutput("resetReqReady", icacheReq.ready, 1'b0);
    checkOutput("resetInstValid", instValid, 1'b0);
    checkOutput("resetInstPc", instPc, 32'h0);

    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    checkOutput("idleReqValid", icacheReq.valid, 1'b0);
    @(negedge clk_i);
    checkOutput("firstReqValid", icacheReq.valid, 1'b1);

    waitHandshakes(4, "blockA");
    @(posedge clk_i); #1;
    instReady     = 1'b0;
    uncachedDrive = 1'b1;

    waitOn(W_INST_VALID, "stallEntry");
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk_i);
      checkOutput("stallInst", instWord, wordAt(32'h8000_0010));
      checkOutput("stallPc", instPc, 32'h8000_0010);
    end
    checkOutput("serveReqValid", icacheReq.valid, 1'b0);
    checkOutput("serveUncached", icacheReq.uncached, 1'b0);
    checkOutput("serveReqAddr", icacheReq.addr, 32'h0);

    pushRange(32'h8000_0010, 4);
    addrQ.push_back(32'h8000_0020);
    addrQ.push_back(32'h0000_1000);
    addrQ.push_back(32'h0000_1010);
    pushRange(32'h0000_1008, 3);
    addrQ.push_back(32'h0000_2000);
    addrQ.push_back(32'h0000_2010);
    pushRange(32'h0000_2004, 3);
    @(posedge clk_i); #1;
    instReady   = 1'b1;
    respLatency = 3;

    waitOn(W_RESP_READY, "waitRedirect");
    applyStimulus(1'b1, 32'h0000_1008);
    @(posedge clk_i); #1;
    applyStimulus(1'b0, 32'h0);
    respLatency = 1;
    @(negedge clk_i);
    checkOutput("discardStillWaiting", icacheReq.ready, 1'b1);

    waitHandshakes(3, "toServeRedirect");
    applyStimulus(1'b1, 32'h0000_2006);
    @(posedge clk_i); #1;
    applyStimulus(1'b0, 32'h0);

    addrQ.push_back(32'h0000_3000);
    pushRange(32'h0000_3000, 2);
    waitHandshakes(3, "blockRedirServe");
    waitOn(W_REQ_VALID, "reqRedirect");
    checkOutput("reqUncached", icacheReq.uncached, 1'b1);
    applyStimulus(1'b1, 32'h0000_3000);
    @(posedge clk_i); #1;
    applyStimulus(1'b0, 32'h0);
    uncachedDrive = 1'b0;
    @(negedge clk_i);
    checkOutput("reqRedirWaitInst", instValid, 1'b0);

    addrQ.push_back(32'hFFFF_FFF0);
    addrQ.push_back(32'h0000_0000);
    addrQ.push_back(32'h0000_0010);
    pushInst(32'hFFFF_FFFC, wordAt(32'hFFFF_FFFC));
    pushRange(32'h0000_0000, 4);
    waitHandshakes(2, "toWrap");
    applyStimulus(1'b1, 32'hFFFF_FFFC);
    @(posedge clk_i); #1;
    applyStimulus(1'b0, 32'h0);

    for (int c = 0; c < 300 && instQ.size() != 0; c++) begin
      @(posedge clk_i); #2;
    end
    instReady = 1'b0;
    checkOutput("drainInstQ", 32'(instQ.size()), 32'd0);
    for (int c = 0; c < 300 && addrQ.size() != 0; c++) begin
      @(posedge clk_i); #2;
    end
    resReady = 1'b0;
    checkOutput("drainAddrQ", 32'(addrQ.size()), 32'd0);

    waitOn(W_INST_VALID, "finalServe");
    checkOutput("finalServePc", instPc, 32'h0000_0010);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("asyncResetInstValid", instValid, 1'b0);
    checkOutput("asyncResetInstPc", instPc, 32'h0);
    checkOutput("asyncResetReqReady", icacheReq.ready, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
